// File: rtl/freqmeter_result_arbiter.sv
// rtl/freqmeter_result_arbiter.sv - round-robin arbiter sharing the result RAM write port among capture channels
module freqmeter_result_arbiter #(
    parameter int CHANNELS = 24,
    parameter int CNT_W    = 24,
    parameter int TS_W     = 30,
    parameter int ADDR_W   = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CHANNELS-1:0]       req_i,
    input  logic [CHANNELS*CNT_W-1:0] cnt_i,
    input  logic [CHANNELS*TS_W-1:0]  ts_i,
    input  logic [CHANNELS-1:0]       en_mask_i,
    input  logic [CHANNELS-1:0]       clr_i,
    output logic [CHANNELS-1:0]       ack_o,
    output logic                      wr_en_o,
    output logic [ADDR_W-1:0]         wr_addr_o,
    output logic [31:0]               wr_data_o,
    output logic [CHANNELS-1:0]       updated_o,
    output logic                      irq_o,
    output logic                      busy_o
);

    localparam int IDX_W = ADDR_W - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_CNT,
        S_WR_TS,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_rr;
    logic [IDX_W-1:0]    r_gnt;
    logic [TS_W-1:0]     r_ts;
    logic [CHANNELS-1:0] r_ack;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;
    logic [CHANNELS-1:0] r_updated;
    logic                r_irq;
    logic                r_busy;

    logic [CHANNELS-1:0] w_eligible;
    logic [CHANNELS-1:0] w_upd_next;
    logic [IDX_W-1:0]    w_sel;
    logic                w_found;
    logic [IDX_W:0]      w_t;

    // Scan upward from the round-robin pointer, wrapping at CHANNELS.
    always_comb begin
        w_eligible = req_i & en_mask_i;
        w_found    = 1'b0;
        w_sel      = '0;
        w_t        = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_t = {1'b0, r_rr} + (IDX_W+1)'(i);
            if (w_t >= (IDX_W+1)'(CHANNELS)) begin
                w_t = w_t - (IDX_W+1)'(CHANNELS);
            end
            if (!w_found && w_eligible[w_t[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_t[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_found) w_next = S_WR_CNT;
            S_WR_CNT: w_next = S_WR_TS;
            S_WR_TS:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Set from the DONE state wins over a same-cycle clear.
    always_comb begin
        w_upd_next = r_updated & ~clr_i;
        if (r_state == S_DONE) begin
            w_upd_next[r_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rr      <= '0;
            r_gnt     <= '0;
            r_ts      <= '0;
            r_ack     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_updated <= '0;
            r_irq     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= (w_next != S_IDLE);
            r_updated <= w_upd_next;
            r_irq     <= |w_upd_next;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt     <= w_sel;
                        r_ts      <= ts_i[w_sel*TS_W +: TS_W];
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= {w_sel, 1'b0};
                        r_wr_data <= 32'(cnt_i[w_sel*CNT_W +: CNT_W]);
                    end
                end
                S_WR_CNT: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= {r_gnt, 1'b1};
                    r_wr_data <= 32'(r_ts);
                end
                S_WR_TS: begin
                    r_ack <= CHANNELS'(1) << r_gnt;
                end
                S_DONE: begin
                    r_rr <= (r_gnt == IDX_W'(CHANNELS-1)) ? '0 : r_gnt + 1'b1;
                end
                default: begin
                    r_ack <= '0;
                end
            endcase
        end
    end

    assign ack_o     = r_ack;
    assign wr_en_o   = r_wr_en;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;
    assign updated_o = r_updated;
    assign irq_o     = r_irq;
    assign busy_o    = r_busy;

endmodule

// File: tb/tb_freqmeter_result_arbiter.sv
// tb/tb_freqmeter_result_arbiter.sv - randomized transaction-model bench for freqmeter_result_arbiter
module tb_freqmeter_result_arbiter;

    localparam int CH = 24;
    localparam int CW = 24;
    localparam int TW = 30;
    localparam int AW = 6;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [CH-1:0]    req;
    logic [CH*CW-1:0] cnt_bus;
    logic [CH*TW-1:0] ts_bus;
    logic [CH-1:0]    en_mask;
    logic [CH-1:0]    clr;
    logic [CH-1:0]    ack;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [31:0]      wr_data;
    logic [CH-1:0]    updated;
    logic             irq;
    logic             busy;

    always #5 clk_i = ~clk_i;

    freqmeter_result_arbiter #(.CHANNELS(CH), .CNT_W(CW), .TS_W(TW), .ADDR_W(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req), .cnt_i(cnt_bus), .ts_i(ts_bus),
        .en_mask_i(en_mask), .clr_i(clr), .ack_o(ack), .wr_en_o(wr_en),
        .wr_addr_o(wr_addr), .wr_data_o(wr_data), .updated_o(updated),
        .irq_o(irq), .busy_o(busy)
    );

    // kind: 0 count write, 1 timestamp write, 2 ack, 3 first idle after ack, 4 idle
    typedef struct {
        int          kind;
        int          ch;
        logic [31:0] data;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          cur;
    int            m_rr;
    logic [CH-1:0] m_upd;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_wr     = 0;
    int ack_log[$];
    int ack_cyc[$];
    int last_ack_ch  = -1;
    int last_ack_cyc = -1;
    bit auto_mode    = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur.kind = 4; cur.ch = 0; cur.data = '0;
        m_rr  = 0;
        m_upd = '0;
    endtask

    // Transaction-level reference: when no transfer is pending, pick the first
    // eligible channel at or after the pointer and schedule its four-cycle transfer.
    task automatic model_edge();
        logic [CH-1:0] elig;
        int            g;
        bit            found;
        exp_t          e;
        m_upd = m_upd & ~clr;
        if (exp_q.size() == 0) begin
            elig  = req & en_mask;
            found = 1'b0;
            g     = 0;
            for (int i = 0; i < CH; i++) begin
                if (!found && elig[(m_rr + i) % CH]) begin
                    found = 1'b1;
                    g     = (m_rr + i) % CH;
                end
            end
            if (found) begin
                e.ch = g;
                e.kind = 0; e.data = 32'(cnt_bus[g*CW +: CW]); exp_q.push_back(e);
                e.kind = 1; e.data = 32'(ts_bus[g*TW +: TW]);  exp_q.push_back(e);
                e.kind = 2; e.data = '0; exp_q.push_back(e);
                e.kind = 3; exp_q.push_back(e);
            end
        end
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur.kind = 4; cur.ch = 0; cur.data = '0;
        end
        if (cur.kind == 3) begin
            m_upd[cur.ch] = 1'b1;
            m_rr = (cur.ch + 1) % CH;
        end
    endtask

    task automatic check_outputs();
        logic [CH-1:0] ea;
        ea = '0;
        if (cur.kind == 2) ea[cur.ch] = 1'b1;
        check_eq("wr_en", 64'(wr_en), 64'(cur.kind < 2));
        if (cur.kind < 2) begin
            check_eq("wr_addr", 64'(wr_addr), 64'(cur.ch * 2 + cur.kind));
            check_eq("wr_data", 64'(wr_data), 64'(cur.data));
        end
        check_eq("ack", 64'(ack), 64'(ea));
        check_eq("updated", 64'(updated), 64'(m_upd));
        check_eq("irq", 64'(irq), 64'(|m_upd));
        check_eq("busy", 64'(busy), 64'(cur.kind < 3));
    endtask

    task automatic observe();
        if (wr_en) n_wr++;
        for (int k = 0; k < CH; k++) begin
            if (ack[k]) begin
                ack_log.push_back(k);
                ack_cyc.push_back(cyc);
                last_ack_ch  = k;
                last_ack_cyc = cyc;
            end
        end
    endtask

    task automatic agent();
        clr = '0;
        for (int k = 0; k < CH; k++) begin
            if (ack[k]) begin
                req[k] = 1'b0;
            end else if (auto_mode && !req[k] && $urandom_range(0, 15) == 0) begin
                req[k] = 1'b1;
                cnt_bus[k*CW +: CW] = CW'($urandom);
                ts_bus[k*TW +: TW]  = TW'($urandom);
            end
        end
        if (auto_mode) begin
            if ($urandom_range(0, 3) == 0) begin
                int kk;
                kk = $urandom_range(0, CH-1);
                cnt_bus[kk*CW +: CW] = CW'($urandom);
                ts_bus[kk*TW +: TW]  = TW'($urandom);
            end
            if ($urandom_range(0, 5) == 0) clr[$urandom_range(0, CH-1)] = 1'b1;
            if ($urandom_range(0, 63) == 0) en_mask = CH'($urandom) | CH'($urandom);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        cyc++;
        model_edge();
        @(negedge clk_i);
        check_outputs();
        observe();
        agent();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ack"}, 64'(ack), 64'(0));
        check_eq({tag, "_wr_en"}, 64'(wr_en), 64'(0));
        check_eq({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
        check_eq({tag, "_wr_data"}, 64'(wr_data), 64'(0));
        check_eq({tag, "_updated"}, 64'(updated), 64'(0));
        check_eq({tag, "_irq"}, 64'(irq), 64'(0));
        check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic check_pair(input string tag, input int a0, input int c0, input int c1);
        check_eq({tag, "_count"}, 64'(ack_log.size() - a0), 64'(2));
        if (ack_log.size() >= a0 + 2) begin
            check_eq({tag, "_first"}, 64'(ack_log[a0]), 64'(c0));
            check_eq({tag, "_second"}, 64'(ack_log[a0+1]), 64'(c1));
        end
    endtask

    initial begin
        int t0;
        int n0;
        int a0;
        rst_i = 1'b1; req = '0; en_mask = '1; clr = '0; cnt_bus = '0; ts_bus = '0;
        model_reset();
        #1 rst_i = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;

        // single request on channel 5
        cnt_bus[5*CW +: CW] = CW'(24'h00ABCD);
        ts_bus[5*TW +: TW]  = TW'(30'h12345678);
        req[5] = 1'b1;
        t0 = cyc; n0 = n_wr;
        run(3);
        check_eq("t1_ack_latency", 64'(last_ack_cyc - t0), 64'(3));
        check_eq("t1_ack_ch", 64'(last_ack_ch), 64'(5));
        run(3);
        check_eq("t1_writes", 64'(n_wr - n0), 64'(2));
        check_eq("t1_updated5", 64'(updated[5]), 64'(1));
        check_eq("t1_irq", 64'(irq), 64'(1));

        // all channels at once from a fresh pointer
        do_reset();
        for (int k = 0; k < CH; k++) begin
            cnt_bus[k*CW +: CW] = CW'($urandom);
            ts_bus[k*TW +: TW]  = TW'($urandom);
        end
        req = '1; n0 = n_wr; a0 = ack_log.size();
        run(CH*4 + 4);
        check_eq("t2_writes", 64'(n_wr - n0), 64'(2*CH));
        check_eq("t2_updated", 64'(updated), 64'(24'hFFFFFF));
        check_eq("t2_acks", 64'(ack_log.size() - a0), 64'(CH));
        if (ack_log.size() >= a0 + CH) begin
            for (int i = 0; i < CH; i++) begin
                check_eq("t2_order", 64'(ack_log[a0+i]), 64'(i));
                if (i > 0) check_eq("t2_spacing", 64'(ack_cyc[a0+i] - ack_cyc[a0+i-1]), 64'(4));
            end
        end

        // pointer wrapped to 0 after channel 23, then fairness after channel 3
        a0 = ack_log.size();
        req[0] = 1'b1; req[23] = 1'b1;
        run(10);
        check_pair("t3_wrap", a0, 0, 23);
        req[3] = 1'b1;
        run(5);
        a0 = ack_log.size();
        req[1] = 1'b1; req[7] = 1'b1;
        run(10);
        check_pair("t3_rr", a0, 7, 1);

        // masked request is ignored until enabled
        en_mask[2] = 1'b0; req[2] = 1'b1;
        n0 = n_wr; a0 = ack_log.size();
        run(100);
        check_eq("t4_masked_writes", 64'(n_wr - n0), 64'(0));
        check_eq("t4_masked_acks", 64'(ack_log.size() - a0), 64'(0));
        en_mask[2] = 1'b1;
        run(1);
        check_eq("t4_unmask_wr", 64'(wr_en), 64'(1));
        run(5);

        // set beats clear in the ack cycle
        clr = '1;
        run(1);
        req[4] = 1'b1;
        run(3);
        clr[4] = 1'b1;
        run(1);
        check_eq("t5_set_wins", 64'(updated[4]), 64'(1));
        run(1);
        clr[4] = 1'b1;
        run(1);
        check_eq("t5_cleared", 64'(updated[4]), 64'(0));
        check_eq("t5_irq_low", 64'(irq), 64'(0));

        // reset during the timestamp write of channel 9
        req[9] = 1'b1;
        run(2);
        check_eq("t6_in_wr_ts", 64'(wr_addr), 64'(19));
        #2 rst_i = 1'b0;
        #1 check_all_zero("t6_async");
        model_reset();
        a0 = ack_log.size();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        check_eq("t6_req_held", 64'(req[9]), 64'(1));
        run(6);
        check_eq("t6_reacks", 64'(ack_log.size() - a0), 64'(1));
        check_eq("t6_ack_ch", 64'(last_ack_ch), 64'(9));

        // randomized traffic, masks, clears and data churn
        auto_mode = 1'b1;
        run(3000);
        auto_mode = 1'b0;
        en_mask = '1;
        run(CH*4 + 20);
        check_eq("drain_req", 64'(req), 64'(0));
        check_eq("drain_busy", 64'(busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freqmeter_result_arbiter.md
Name: freqmeter_result_arbiter

Overview:
Shares the single result-RAM write port among the frequency-meter input channels; there is one channel per Fin bit, 24 by default. Each channel's capture logic raises a request with a latched period count and timestamp. The arbiter grants channels round-robin, writes count and timestamp to a per-channel RAM slot, and acknowledges the channel. It keeps sticky per-channel "updated" flags and an interrupt line for the CPU.

Parameters:
CHANNELS, 24, number of requesting channels (1..32)
CNT_W, 24, width of captured period count (<=32)
TS_W, 30, width of captured timestamp (<=32)
ADDR_W, 6, result RAM word address width; 2^(ADDR_W-1) >= CHANNELS required

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-low reset
req_i  in  CHANNELS  per-channel request, held by channel until its ack
cnt_i  in  CHANNELS*CNT_W  flattened counts; channel k at [k*CNT_W +: CNT_W]
ts_i  in  CHANNELS*TS_W  flattened timestamps; channel k at [k*TS_W +: TS_W]
en_mask_i  in  CHANNELS  channel enable; 0 = request ignored
clr_i  in  CHANNELS  write-1-to-clear pulses for updated_o
ack_o  out  CHANNELS  one-cycle acknowledge to the granted channel
wr_en_o  out  1  result RAM write strobe
wr_addr_o  out  ADDR_W  result RAM word address
wr_data_o  out  32  result RAM write data
updated_o  out  CHANNELS  sticky "new result" flags
irq_o  out  1  OR of updated_o
busy_o  out  1  1 in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset (rst_i=0, asynchronous): state=IDLE, rr pointer=0, and ack_o, wr_en_o, wr_addr_o, wr_data_o, updated_o, irq_o and busy_o all reset to 0.
- FSM states: IDLE -> WR_CNT -> WR_TS -> DONE -> IDLE. No other transitions.
- IDLE:
  - eligible = req_i & en_mask_i.
  - If eligible != 0, select the first set bit scanning upward from rr pointer, wrapping CHANNELS-1 -> 0.
  - Register the grant index, and latch that channel's cnt/ts slices into internal holding registers.
  - Next state WR_CNT.
  - If eligible = 0, stay in IDLE.
- WR_CNT (one cycle): wr_en_o=1, wr_addr_o={gnt,1'b0}, wr_data_o=count zero-extended to 32.
- WR_TS (one cycle): wr_en_o=1, wr_addr_o={gnt,1'b1}, wr_data_o=timestamp zero-extended to 32.
- DONE (one cycle):
  - ack_o[gnt]=1, all other ack bits 0.
  - updated_o[gnt] set.
  - rr pointer = gnt+1, wrapping to 0 when gnt = CHANNELS-1.
  - wr_en_o=0.
- Timing:
  - Latency from req sampled in IDLE to first write strobe is 1 cycle; to ack is 3 cycles.
  - Minimum 4 cycles per transfer, so back-to-back grants start every 4 cycles.
  - wr_en_o is 0 in IDLE and DONE.
- Channel side rules:
  - A channel must deassert req the cycle after ack; the arbiter does not sample req in DONE.
  - A req that drops after grant does not abort the transfer: data is already latched, and the write and ack complete.
  - Masked channels are never granted or acked. A mask cleared mid-transfer does not abort the transfer.
  - cnt_i/ts_i changes after grant have no effect on the transfer in progress.
- updated_o: cleared by clr_i[k]=1. If set (DONE) and clear hit the same bit in the same cycle, set wins. irq_o = |updated_o, registered, so it lags updated_o by 0 cycles: it is computed from next-state flags.
- Unused wr_addr_o MSBs for CHANNELS < 2^(ADDR_W-1) are simply never produced.
- Reset mid-transfer: the FSM aborts immediately, no ack is issued, and a partially written slot is left as-is. The channel keeps req high and is re-served after reset.

Test Plan:
1. Single request: en_mask=all 1, req_i[5]=1, cnt=0x00ABCD, ts=0x12345678.
   Expect writes addr 10 data 0x0000ABCD, then addr 11 data 0x12345678, then ack_o[5] pulse 3 cycles after req, updated_o[5]=1, irq_o=1.
2. All 24 request simultaneously after reset (rr=0): grants in order 0,1,...,23.
   Expect exactly 48 writes, acks spaced 4 cycles apart, updated_o=0xFFFFFF.
3. Round-robin fairness: ch3 served (rr=4), then req on ch1 and ch7 together. Expect ch7 granted before ch1. Wrap case: gnt=23 makes rr=0.
4. Masking: req_i[2]=1 with en_mask_i[2]=0 for 100 cycles. Expect no write and no ack. Setting the mask bit then produces the transfer within 1 cycle.
5. Clear collision: clr_i[4]=1 in the same cycle as DONE for ch4. Expect updated_o[4]=1. A later clr_i[4] pulse gives updated_o[4]=0, and irq_o=0 if no other flags are set.
6. Reset mid-transfer: assert rst_i=0 during WR_TS of ch9.
   Expect all outputs 0 asynchronously and no ack. After release with req_i[9] still 1, the full transfer of ch9 is repeated.
